// File: rtl/tlp_tx_framer_pkg.sv
// rtl/tlp_tx_framer_pkg.sv - shared TLP encodings, framer state type and length helpers
package pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

  localparam int MAX_LEN_DW = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } framer_state_t;

  // A zero Length field encodes the maximum TLP length.
  function automatic logic [10:0] tlp_len_dw(input logic [9:0] length);
    return (length == 10'd0) ? 11'(MAX_LEN_DW) : {1'b0, length};
  endfunction

  function automatic logic fmt_is_4dw(input logic [2:0] fmt);
    return (fmt & FMT_4DW_NODATA) == FMT_4DW_NODATA;
  endfunction

  function automatic logic fmt_has_data(input logic [2:0] fmt);
    return (fmt & FMT_3DW_DATA) == FMT_3DW_DATA;
  endfunction

endpackage

// File: rtl/tlp_tx_framer_if.sv
// rtl/tlp_tx_framer_if.sv - request, payload and transmit stream bundle for the TLP framer
interface tlp_tx_framer_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [4:0]  req_type;
  logic [2:0]  req_tc;
  logic        req_td;
  logic        req_ep;
  logic [1:0]  req_attr;
  logic [9:0]  req_length;
  logic [15:0] req_requester_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_last_be;
  logic [3:0]  req_first_be;
  logic [63:0] req_addr;

  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] pl_data;

  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output req_valid, req_fmt, req_type, req_tc, req_td, req_ep, req_attr,
           req_length, req_requester_id, req_tag, req_last_be, req_first_be,
           req_addr, pl_valid, pl_data, tx_ready,
    input  req_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
  );

  modport slave (
    input  req_valid, req_fmt, req_type, req_tc, req_td, req_ep, req_attr,
           req_length, req_requester_id, req_tag, req_last_be, req_first_be,
           req_addr, pl_valid, pl_data, tx_ready,
    output req_ready, pl_ready, tx_valid, tx_data, tx_sop, tx_eop
  );

endinterface

// File: rtl/tlp_tx_framer_hdr_pack.sv
// rtl/tlp_tx_framer_hdr_pack.sv - packs latched request fields into 3DW/4DW PCIe header DWs
module tlp_hdr_pack (
  input  logic [2:0]  fmt,
  input  logic [4:0]  tlp_type,
  input  logic [2:0]  tc,
  input  logic        td,
  input  logic        ep,
  input  logic [1:0]  attr,
  input  logic [9:0]  length,
  input  logic [15:0] requester_id,
  input  logic [7:0]  tag,
  input  logic [3:0]  last_be,
  input  logic [3:0]  first_be,
  input  logic [63:2] addr,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2,
  output logic [31:0] dw3,
  output logic [1:0]  hdr_last
);
  import pcie_tlp_pkg::*;

  always_comb begin
    dw0 = {fmt, tlp_type, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, length};
    dw1 = {requester_id, tag, last_be, first_be};
    if (fmt_is_4dw(fmt)) begin
      dw2      = addr[63:32];
      dw3      = {addr[31:2], 2'b00};
      hdr_last = 2'd3;
    end else begin
      // 3DW headers carry only the low address; the upper half is dropped.
      dw2      = {addr[31:2], 2'b00};
      dw3      = 32'd0;
      hdr_last = 2'd2;
    end
  end

endmodule

// File: rtl/tlp_tx_framer.sv
// rtl/tlp_tx_framer.sv - frames decoded TLP requests into a 32-bit header+payload transmit stream
module tlp_tx_framer #(
  parameter int MAX_PAYLOAD_DW = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  tlp_tx_framer_if.slave   bus,
  output logic             len_err,
  output logic [CNT_W-1:0] tlp_count
);
  import pcie_tlp_pkg::*;

  localparam logic [10:0] MAX_DW = 11'(MAX_PAYLOAD_DW);

  framer_state_t state;
  logic          req_ready_r;
  logic [1:0]    hdr_idx;
  logic [10:0]   pl_cnt;

  logic [2:0]    r_fmt;
  logic [4:0]    r_type;
  logic [2:0]    r_tc;
  logic          r_td;
  logic          r_ep;
  logic [1:0]    r_attr;
  logic [9:0]    r_length;
  logic [15:0]   r_rid;
  logic [7:0]    r_tag;
  logic [3:0]    r_last_be;
  logic [3:0]    r_first_be;
  logic [63:2]   r_addr;

  logic [31:0]   dw0, dw1, dw2, dw3;
  logic [1:0]    hdr_last;
  logic [10:0]   in_len_dw;
  logic          unused_req_addr_lo;

  logic          tx_valid_c;
  logic [31:0]   tx_data_c;
  logic          tx_sop_c;
  logic          tx_eop_c;
  logic          pl_ready_c;

  assign in_len_dw          = tlp_len_dw(bus.req_length);
  assign unused_req_addr_lo = ^bus.req_addr[1:0];

  tlp_hdr_pack u_hdr_pack (
    .fmt          (r_fmt),
    .tlp_type     (r_type),
    .tc           (r_tc),
    .td           (r_td),
    .ep           (r_ep),
    .attr         (r_attr),
    .length       (r_length),
    .requester_id (r_rid),
    .tag          (r_tag),
    .last_be      (r_last_be),
    .first_be     (r_first_be),
    .addr         (r_addr),
    .dw0          (dw0),
    .dw1          (dw1),
    .dw2          (dw2),
    .dw3          (dw3),
    .hdr_last     (hdr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready_r <= 1'b1;
      len_err     <= 1'b0;
      tlp_count   <= '0;
      hdr_idx     <= 2'd0;
      pl_cnt      <= 11'd0;
      r_fmt       <= '0;
      r_type      <= '0;
      r_tc        <= '0;
      r_td        <= 1'b0;
      r_ep        <= 1'b0;
      r_attr      <= '0;
      r_length    <= '0;
      r_rid       <= '0;
      r_tag       <= '0;
      r_last_be   <= '0;
      r_first_be  <= '0;
      r_addr      <= '0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_fmt      <= bus.req_fmt;
            r_type     <= bus.req_type;
            r_tc       <= bus.req_tc;
            r_td       <= bus.req_td;
            r_ep       <= bus.req_ep;
            r_attr     <= bus.req_attr;
            r_length   <= bus.req_length;
            r_rid      <= bus.req_requester_id;
            r_tag      <= bus.req_tag;
            r_last_be  <= bus.req_last_be;
            r_first_be <= bus.req_first_be;
            r_addr     <= bus.req_addr[63:2];
            // Oversized writes are dropped here; nothing reaches the stream.
            if (fmt_has_data(bus.req_fmt) && (in_len_dw > MAX_DW)) begin
              len_err <= 1'b1;
            end else begin
              state       <= ST_HDR;
              hdr_idx     <= 2'd0;
              req_ready_r <= 1'b0;
            end
          end
        end
        ST_HDR: begin
          if (bus.tx_ready) begin
            if (hdr_idx == hdr_last) begin
              if (fmt_has_data(r_fmt)) begin
                state  <= ST_PAYLOAD;
                pl_cnt <= tlp_len_dw(r_length);
              end else begin
                state       <= ST_IDLE;
                req_ready_r <= 1'b1;
                tlp_count   <= tlp_count + CNT_W'(1);
              end
            end else begin
              hdr_idx <= hdr_idx + 2'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (bus.pl_valid && bus.tx_ready) begin
            pl_cnt <= pl_cnt - 11'd1;
            if (pl_cnt == 11'd1) begin
              state       <= ST_IDLE;
              req_ready_r <= 1'b1;
              tlp_count   <= tlp_count + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Header beats come from captured registers; payload beats pass straight through.
  always_comb begin
    tx_valid_c = 1'b0;
    tx_data_c  = 32'd0;
    tx_sop_c   = 1'b0;
    tx_eop_c   = 1'b0;
    pl_ready_c = 1'b0;
    case (state)
      ST_HDR: begin
        tx_valid_c = 1'b1;
        case (hdr_idx)
          2'd0:    tx_data_c = dw0;
          2'd1:    tx_data_c = dw1;
          2'd2:    tx_data_c = dw2;
          default: tx_data_c = dw3;
        endcase
        tx_sop_c = (hdr_idx == 2'd0);
        tx_eop_c = (hdr_idx == hdr_last) && !fmt_has_data(r_fmt);
      end
      ST_PAYLOAD: begin
        tx_valid_c = bus.pl_valid;
        tx_data_c  = bus.pl_data;
        tx_eop_c   = (pl_cnt == 11'd1);
        pl_ready_c = bus.tx_ready;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready_r;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.tx_sop    = tx_sop_c;
  assign bus.tx_eop    = tx_eop_c;
  assign bus.pl_ready  = pl_ready_c;

endmodule

// File: tb/tb_tlp_tx_framer.sv
// tb/tb_tlp_tx_framer.sv - directed scoreboard bench for tlp_tx_framer
module tb_tlp_tx_framer;
  import pcie_tlp_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  length;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [3:0]  lbe;
    logic [3:0]  fbe;
    logic [63:0] addr;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       len_err;
  logic [1:0] tlp_count;

  tlp_tx_framer_if bus();

  tlp_tx_framer #(.MAX_PAYLOAD_DW(128), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .len_err   (len_err),
    .tlp_count (tlp_count)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  logic [31:0] pl_q[$];
  logic [31:0] pl_stage[$];
  int          passed = 0;
  int          total = 0;
  int          txv_cnt = 0;
  int          lerr_cnt = 0;
  int          pl_taken = 0;
  logic        held_v = 1'b0;
  logic [33:0] held = '0;
  bit          bp_mode = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;
  int          bp_idx = 0;
  logic [1:0]  exp_cnt = 2'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic update_pl();
    bus.pl_valid = (pl_q.size() != 0);
    bus.pl_data  = (pl_q.size() != 0) ? pl_q[0] : 32'd0;
  endtask

  // One clock: check outputs at negedge, then update inputs just after posedge.
  task automatic cycle();
    beat_t       e;
    logic [33:0] cur;
    logic        tx_acc, pl_acc, req_acc;
    @(negedge clk);
    cur = {bus.tx_sop, bus.tx_eop, bus.tx_data};
    if (held_v && bus.tx_valid) chk("hold_stable", cur, held);
    held_v = bus.tx_valid && !bus.tx_ready;
    held   = cur;
    chk("pl_ready_stall", bus.pl_ready & ~bus.tx_ready, 1'b0);
    if (bus.tx_valid) txv_cnt++;
    if (len_err) lerr_cnt++;
    tx_acc  = bus.tx_valid && bus.tx_ready;
    pl_acc  = bus.pl_valid && bus.pl_ready;
    req_acc = bus.req_valid && bus.req_ready;
    if (tx_acc) begin
      chk("beat_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", cur, {e.sop, e.eop, e.data});
      end
    end
    @(posedge clk);
    #1;
    if (req_acc) bus.req_valid = 1'b0;
    if (pl_acc && pl_q.size() != 0) begin
      void'(pl_q.pop_front());
      pl_taken++;
    end
    update_pl();
    bus.tx_ready = bp_mode ? bp_pat[bp_idx % 4] : 1'b1;
    bp_idx++;
  endtask

  function automatic req_t mk_req(input logic [2:0] fmt, input logic [9:0] length,
                                  input logic [15:0] rid, input logic [7:0] tag,
                                  input logic [3:0] fbe, input logic [63:0] addr);
    req_t r;
    r.fmt = fmt; r.typ = 5'd0; r.tc = 3'd0; r.td = 1'b0; r.ep = 1'b0; r.attr = 2'd0;
    r.length = length; r.rid = rid; r.tag = tag; r.lbe = 4'h0; r.fbe = fbe; r.addr = addr;
    return r;
  endfunction

  task automatic push_beat(input logic [31:0] data, input logic sop, input logic eop);
    beat_t b;
    b.data = data; b.sop = sop; b.eop = eop;
    exp_q.push_back(b);
  endtask

  task automatic push_tlp(input req_t r);
    logic [31:0] h [4];
    int nh;
    int np;
    h[0] = (32'(r.fmt) << 29) | (32'(r.typ) << 24) | (32'(r.tc) << 20) | (32'(r.td) << 15)
         | (32'(r.ep) << 14) | (32'(r.attr) << 12) | 32'(r.length);
    h[1] = (32'(r.rid) << 16) | (32'(r.tag) << 8) | (32'(r.lbe) << 4) | 32'(r.fbe);
    h[3] = 32'd0;
    if (r.fmt[0]) begin
      h[2] = r.addr[63:32];
      h[3] = r.addr[31:0] & 32'hFFFF_FFFC;
      nh = 4;
    end else begin
      h[2] = r.addr[31:0] & 32'hFFFF_FFFC;
      nh = 3;
    end
    for (int i = 0; i < nh; i++) push_beat(h[i], (i == 0), (i == nh - 1) && !r.fmt[1]);
    if (r.fmt[1]) begin
      np = pl_stage.size();
      for (int i = 0; i < np; i++) begin
        push_beat(pl_stage[i], 1'b0, (i == np - 1));
        pl_q.push_back(pl_stage[i]);
      end
    end
    pl_stage.delete();
    update_pl();
  endtask

  task automatic drive_req(input req_t r);
    bus.req_fmt = r.fmt; bus.req_type = r.typ; bus.req_tc = r.tc; bus.req_td = r.td;
    bus.req_ep = r.ep; bus.req_attr = r.attr; bus.req_length = r.length;
    bus.req_requester_id = r.rid; bus.req_tag = r.tag; bus.req_last_be = r.lbe;
    bus.req_first_be = r.fbe; bus.req_addr = r.addr;
    bus.req_valid = 1'b1;
  endtask

  task automatic run_tlp(input req_t r, input bit use_model, input string tag);
    int n;
    if (use_model) push_tlp(r);
    drive_req(r);
    cycle();
    chk({tag, "_latency"}, {bus.tx_valid, bus.tx_sop}, 2'b11);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    exp_cnt = exp_cnt + 2'd1;
    chk({tag, "_count"}, tlp_count, exp_cnt);
  endtask

  task automatic run_reject(input req_t r, input string tag);
    txv_cnt  = 0;
    lerr_cnt = 0;
    drive_req(r);
    repeat (5) cycle();
    chk({tag, "_taken"}, bus.req_valid, 1'b0);
    chk({tag, "_len_err_cycles"}, lerr_cnt, 1);
    chk({tag, "_no_tx"}, txv_cnt, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 1'b1);
    chk({tag, "_count"}, tlp_count, exp_cnt);
  endtask

  task automatic push_mwr_consts();
    push_beat(32'h6000_0002, 1'b1, 1'b0);
    push_beat(32'h0210_3CFF, 1'b0, 1'b0);
    push_beat(32'hABCD_0000, 1'b0, 1'b0);
    push_beat(32'h8000_0004, 1'b0, 1'b0);
    push_beat(32'hDEAD_BEEF, 1'b0, 1'b0);
    push_beat(32'hCAFE_F00D, 1'b0, 1'b1);
    pl_q.push_back(32'hDEAD_BEEF);
    pl_q.push_back(32'hCAFE_F00D);
    update_pl();
  endtask

  initial begin
    req_t r;
    int   n;
    int   start;
    drive_req(mk_req(3'd0, 10'd0, 16'd0, 8'd0, 4'd0, 64'd0));
    bus.req_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    update_pl();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.req_ready, bus.tx_valid, bus.tx_sop, bus.tx_eop,
                        bus.pl_ready, len_err, tlp_count}, 8'b1000_0000);
    rst = 1'b0;
    cycle();
    chk("idle_after_reset", {bus.req_ready, bus.tx_valid}, 2'b10);

    r = mk_req(FMT_3DW_NODATA, 10'd1, 16'h0108, 8'h05, 4'hF, 64'h0000_0000_1234_5678);
    push_beat(32'h0000_0001, 1'b1, 1'b0);
    push_beat(32'h0108_050F, 1'b0, 1'b0);
    push_beat(32'h1234_5678, 1'b0, 1'b1);
    run_tlp(r, 1'b0, "mrd3");

    r = mk_req(FMT_4DW_DATA, 10'd2, 16'h0210, 8'h3C, 4'hF, 64'hABCD_0000_8000_0004);
    r.lbe = 4'hF;
    push_mwr_consts();
    run_tlp(r, 1'b0, "mwr4");

    bp_mode = 1'b1;
    bp_idx  = 0;
    push_mwr_consts();
    run_tlp(r, 1'b0, "mwr4_bp");
    bp_mode = 1'b0;
    bus.tx_ready = 1'b1;

    r = mk_req(FMT_3DW_DATA, 10'd129, 16'h0300, 8'h10, 4'hF, 64'h0000_0000_0000_1000);
    run_reject(r, "len129");
    r.length = 10'd0;
    run_reject(r, "len1024");

    r = mk_req(FMT_3DW_NODATA, 10'd0, 16'h0301, 8'h11, 4'h1, 64'h0000_0000_0000_0040);
    run_tlp(r, 1'b1, "mrd_len0");

    r = mk_req(FMT_3DW_DATA, 10'd128, 16'h0302, 8'h12, 4'hF, 64'h0000_0000_0000_2000);
    for (int i = 0; i < 128; i++) pl_stage.push_back(32'hA5A5_0000 | 32'(i));
    run_tlp(r, 1'b1, "mwr_len128");

    r = mk_req(FMT_3DW_DATA, 10'd4, 16'h0303, 8'h13, 4'hF, 64'h0000_0000_0000_3000);
    for (int i = 0; i < 4; i++) pl_stage.push_back(32'h1111_0000 + 32'(i));
    push_tlp(r);
    drive_req(r);
    start = pl_taken;
    n = 0;
    while ((pl_taken - start) < 2 && n < 100) begin
      cycle();
      n++;
    end
    chk("midrst_two_taken", pl_taken - start, 2);
    rst = 1'b1;
    cycle();
    chk("midrst_state", {bus.tx_valid, bus.pl_ready, bus.req_ready, tlp_count}, 5'b00100);
    exp_q.delete();
    pl_q.delete();
    update_pl();
    held_v  = 1'b0;
    exp_cnt = 2'd0;
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      r = mk_req((k == 2) ? FMT_4DW_NODATA : FMT_3DW_NODATA, 10'(k + 1), 16'h0400 + 16'(k),
                 8'(8'h20 + k), 4'hF, {32'h0000_00F0 + 32'(k), 32'h0000_1007 + 32'(k * 16)});
      if (k == 3) begin
        r.typ = 5'b00100; r.tc = 3'b101; r.td = 1'b1; r.ep = 1'b1; r.attr = 2'b10;
        r.lbe = 4'h3; r.fbe = 4'hC;
      end
      run_tlp(r, 1'b1, $sformatf("wrap%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
